scroll_seg_driver: RTL and testbench
====================================

Name: scroll_seg_driver

Overview:
- Consumer end of the button/switch conditioning path for the scrolling display.
- Takes the debounced reset pulse (S0) and the pause level (SW7) and drives an 8-digit multiplexed 7-segment display.
- The display shows an 8-character window of a fixed 16-character hex message, scrolling one position left per scroll tick and wrapping modulo 16.
- Contains its own input synchroniser and edge detector, because the upstream pulse is generated in a slow clock domain.

Parameters:
- SCAN_DIV, 100000, clk cycles per digit scan slot (1 ms at 100 MHz).
- SCROLL_DIV, 50000000, clk cycles per scroll step (0.5 s at 100 MHz); minimum value 2.
- BLINK_DIV, 50000000, clk cycles per blink phase; used only with PAUSE_BLINK_EN.

Ports:
- clk  input  1  100 MHz system clock.
- rst  input  1  synchronous, active-high reset.
- restart_in  input  1  debounced S0; asynchronous to clk; may stay high for many clk cycles.
- pause_in  input  1  debounced SW7 level; 1 = scrolling frozen.
- seg_out  output  8  segments, active-high; [0]=a … [6]=g, [7]=dp. dp is always 0.
- an_out  output  8  digit enables, active-high, one-hot; [7] = leftmost digit.
- pos_out  output  4  current window start index, 0..15.

Behaviour:
- Message ROM: msg[i] = i for i = 0..15.
- Glyphs: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
- Synchronisers: restart_in and pause_in each pass through a 2-flop synchroniser.
- restart_evt: rising edge of the synchronised restart, i.e. a 1-cycle pulse. A held-high restart_in produces exactly one event.
- Scan counter: 0..SCAN_DIV-1, free-running, never affected by pause or restart.
  - At wrap, scan_idx increments 0..7 and wraps to 0.
- Scroll counter:
  - When sync_pause = 0: counts 0..SCROLL_DIV-1. At SCROLL_DIV-1 it wraps to 0 and pos <= (pos+1) mod 16 (15 -> 0).
  - When sync_pause = 1: holds its value and pos holds, so resume continues from the frozen count.
- Restart: restart_evt sets pos <= 0 and scroll counter <= 0.
  - Restart has priority over a coincident scroll wrap.
  - Restart while paused still zeroes pos; the display stays paused.
- Outputs are registered, 1-cycle latency from scan_idx/pos:
  - an_out = 8'h80 >> scan_idx.
  - seg_out = glyph(msg[(pos + scan_idx) mod 16]), 4-bit wrap-around add.
  - Digit an_out[7-k] therefore shows msg[(pos+k) mod 16].
- pos_out is a registered copy of pos, updated in the same cycle as pos.
- Reset values: pos = 0, scan_idx = 0, all counters = 0, synchroniser/edge flops = 0, an_out = 8'h80, seg_out = 8'h3F, pos_out = 0.
- rst asserted mid-scroll or mid-scan: every state element returns to its reset value on the next clk edge. The restart edge detector's previous-value flop is cleared, so a restart_in still high after rst is released generates one event 3 cycles later.

Optional Feature:
- Macro: PAUSE_BLINK_EN.
- Defined:
  - A blink counter 0..BLINK_DIV-1 runs while sync_pause = 1 and toggles blink_off at each wrap.
  - While paused and blink_off = 1, seg_out = 8'h00; an_out keeps scanning.
  - Leaving pause clears both the blink counter and blink_off immediately, so segments reappear within 1 cycle.
  - rst clears both.
- Undefined: no blink logic; segments are never blanked by pause.

Test Plan (SCAN_DIV=4, SCROLL_DIV=64, BLINK_DIV=16):
1. Release rst, idle inputs -> an_out 80,40,…,01 with each value held 4 cycles, cycling. seg_out follows 3F,06,5B,4F,66,6D,7D,07 (digits 0..7). After 64 cycles pos_out = 1 and the leftmost digit shows 06.
2. Run 15 scroll steps (960 cycles), then one more step -> pos_out 15 then 0. At pos 15, digit k=1 (an_out=40) shows 3F (wrap-around).
3. Raise pause_in at pos_out=3, hold 500 cycles -> pos_out stays 3 and scan continues. Drop pause_in -> pos_out = 4 after the remaining scroll count elapses, not a full 64 cycles.
4. At pos_out=7, drive restart_in high for 200 cycles -> exactly one event. pos_out = 0 three cycles after the rise and stays 0 until 64 cycles later.
5. Coincident restart_evt and scroll-counter wrap -> pos_out = 0, not pos+1. Assert rst mid-scroll -> next cycle an_out = 80, seg_out = 3F, pos_out = 0.
6. (PAUSE_BLINK_EN) Pause for 64 cycles -> seg_out alternates normal and 00 every 16 cycles while an_out scans. Unpause during a blank phase -> seg_out nonzero within 1 cycle.

Source files
------------

// File: rtl/scroll_seg_driver.sv
`default_nettype none
// ============================================================================
// Module  : scroll_seg_driver
// Brief   : Scrolls a 16-digit hex message through an 8-digit multiplexed
//           7-segment display. Optional pause blink via PAUSE_BLINK_EN.
// Revision: 1.0 - initial release
// ============================================================================
module scroll_seg_driver #(
  parameter int SCAN_DIV   = 100000,
  parameter int SCROLL_DIV = 50000000
`ifdef PAUSE_BLINK_EN
  ,
  parameter int BLINK_DIV  = 50000000
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       restart_in,
  input  logic       pause_in,
  output logic [7:0] seg_out,
  output logic [7:0] an_out,
  output logic [3:0] pos_out
);

  localparam int c_SCAN_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int c_SCROLL_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam logic [c_SCAN_W-1:0]   c_SCAN_MAX   = c_SCAN_W'(SCAN_DIV - 1);
  localparam logic [c_SCROLL_W-1:0] c_SCROLL_MAX = c_SCROLL_W'(SCROLL_DIV - 1);

  logic [1:0]            r_restart_sync;
  logic [1:0]            r_pause_sync;
  logic                  r_restart_prev;
  logic [c_SCAN_W-1:0]   r_scan_cnt;
  logic [2:0]            r_scan_idx;
  logic [c_SCROLL_W-1:0] r_scroll_cnt;
  logic [3:0]            r_pos;
  logic [7:0]            r_an;
  logic [7:0]            r_seg;

  logic                  w_sync_pause;
  logic                  w_restart_evt;
  logic                  w_blank;
  logic [3:0]            w_glyph_idx;

  function automatic logic [7:0] f_glyph(input logic [3:0] d);
    logic [7:0] g;
    case (d)
      4'h0:    g = 8'h3F;
      4'h1:    g = 8'h06;
      4'h2:    g = 8'h5B;
      4'h3:    g = 8'h4F;
      4'h4:    g = 8'h66;
      4'h5:    g = 8'h6D;
      4'h6:    g = 8'h7D;
      4'h7:    g = 8'h07;
      4'h8:    g = 8'h7F;
      4'h9:    g = 8'h6F;
      4'hA:    g = 8'h77;
      4'hB:    g = 8'h7C;
      4'hC:    g = 8'h39;
      4'hD:    g = 8'h5E;
      4'hE:    g = 8'h79;
      default: g = 8'h71;
    endcase
    return g;
  endfunction

  // Both inputs originate in a slower clock domain, hence the 2-flop stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_restart_sync <= 2'b00;
      r_pause_sync   <= 2'b00;
      r_restart_prev <= 1'b0;
    end else begin
      r_restart_sync <= {r_restart_sync[0], restart_in};
      r_pause_sync   <= {r_pause_sync[0], pause_in};
      r_restart_prev <= r_restart_sync[1];
    end
  end

  assign w_sync_pause  = r_pause_sync[1];
  assign w_restart_evt = r_restart_sync[1] & ~r_restart_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scan_cnt <= '0;
      r_scan_idx <= 3'd0;
    end else if (r_scan_cnt == c_SCAN_MAX) begin
      r_scan_cnt <= '0;
      r_scan_idx <= r_scan_idx + 3'd1;
    end else begin
      r_scan_cnt <= r_scan_cnt + 1'b1;
    end
  end

  // Restart wins over a coincident scroll wrap; pause freezes count and pos.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scroll_cnt <= '0;
      r_pos        <= 4'd0;
    end else if (w_restart_evt) begin
      r_scroll_cnt <= '0;
      r_pos        <= 4'd0;
    end else if (!w_sync_pause) begin
      if (r_scroll_cnt == c_SCROLL_MAX) begin
        r_scroll_cnt <= '0;
        r_pos        <= r_pos + 4'd1;
      end else begin
        r_scroll_cnt <= r_scroll_cnt + 1'b1;
      end
    end
  end

`ifdef PAUSE_BLINK_EN
  localparam int c_BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [c_BLINK_W-1:0] c_BLINK_MAX = c_BLINK_W'(BLINK_DIV - 1);

  logic [c_BLINK_W-1:0] r_blink_cnt;
  logic                 r_blink_off;

  always_ff @(posedge clk) begin
    if (rst || !w_sync_pause) begin
      r_blink_cnt <= '0;
      r_blink_off <= 1'b0;
    end else if (r_blink_cnt == c_BLINK_MAX) begin
      r_blink_cnt <= '0;
      r_blink_off <= ~r_blink_off;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end

  assign w_blank = w_sync_pause & r_blink_off;
`else
  assign w_blank = 1'b0;
`endif

  assign w_glyph_idx = r_pos + {1'b0, r_scan_idx};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_an  <= 8'h80;
      r_seg <= 8'h3F;
    end else begin
      r_an  <= 8'h80 >> r_scan_idx;
      r_seg <= w_blank ? 8'h00 : f_glyph(w_glyph_idx);
    end
  end

  assign an_out  = r_an;
  assign seg_out = r_seg;
  assign pos_out = r_pos;

endmodule
`default_nettype wire

// File: tb/tb_scroll_seg_driver.sv
`default_nettype none
// ============================================================================
// Module  : tb_scroll_seg_driver
// Brief   : Directed bench for scroll_seg_driver with a cycle-level model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_scroll_seg_driver;

  localparam int SCAN_DIV   = 4;
  localparam int SCROLL_DIV = 64;
  localparam int BLINK_DIV  = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       restart_in;
  logic       pause_in;
  logic [7:0] seg_out;
  logic [7:0] an_out;
  logic [3:0] pos_out;

  int checks = 0;
  int errors = 0;

  scroll_seg_driver #(
    .SCAN_DIV  (SCAN_DIV),
    .SCROLL_DIV(SCROLL_DIV)
`ifdef PAUSE_BLINK_EN
    ,
    .BLINK_DIV (BLINK_DIV)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .restart_in(restart_in),
    .pause_in  (pause_in),
    .seg_out   (seg_out),
    .an_out    (an_out),
    .pos_out   (pos_out)
  );

  always #5 clk = ~clk;

  logic [7:0] GLYPH [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                             8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  // Model: cycles since reset give the scan slot; message window is (pos+k)%16.
  int         m_cyc, m_pos, m_scroll, m_blink;
  bit         m_valid = 1'b0;
  bit         m_p1, m_p2, m_r1, m_r2, m_rprev, m_off, m_evt, m_blank;
  logic [7:0] exp_an, exp_seg;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1;
      m_cyc = 0; m_pos = 0; m_scroll = 0; m_blink = 0; m_off = 1'b0;
      m_p1 = 1'b0; m_p2 = 1'b0; m_r1 = 1'b0; m_r2 = 1'b0; m_rprev = 1'b0;
      exp_an = 8'h80; exp_seg = 8'h3F;
    end else begin
      m_blank = 1'b0;
`ifdef PAUSE_BLINK_EN
      m_blank = m_p2 && m_off;
`endif
      exp_an  = 8'h80 >> ((m_cyc / SCAN_DIV) % 8);
      exp_seg = m_blank ? 8'h00 : GLYPH[(m_pos + (m_cyc / SCAN_DIV) % 8) % 16];
      m_evt = m_r2 && !m_rprev;
      if (m_evt) begin
        m_pos = 0; m_scroll = 0;
      end else if (!m_p2) begin
        if (m_scroll == SCROLL_DIV - 1) begin
          m_scroll = 0; m_pos = (m_pos + 1) % 16;
        end else m_scroll++;
      end
      if (!m_p2) begin
        m_blink = 0; m_off = 1'b0;
      end else if (m_blink == BLINK_DIV - 1) begin
        m_blink = 0; m_off = !m_off;
      end else m_blink++;
      m_rprev = m_r2; m_r2 = m_r1; m_r1 = restart_in;
      m_p2 = m_p1; m_p1 = pause_in;
      m_cyc = (m_cyc + 1) % (8 * SCAN_DIV);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_an", {24'd0, an_out}, {24'd0, exp_an});
      chk("model_seg", {24'd0, seg_out}, {24'd0, exp_seg});
      chk("model_pos", {28'd0, pos_out}, m_pos);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_pos(input logic [3:0] v, input int budget);
    int n = 0;
    while (pos_out !== v && n < budget) begin tick(1); n++; end
    chk("wait_pos", {28'd0, pos_out}, {28'd0, v});
  endtask

  task automatic wait_an(input logic [7:0] v);
    int n = 0;
    while (an_out !== v && n < 40) begin tick(1); n++; end
    chk("wait_an", {24'd0, an_out}, {24'd0, v});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  int n;
  int cur;

  initial begin
    rst = 1'b1; restart_in = 1'b0; pause_in = 1'b0;
    tick(3);
    chk("rst_an", {24'd0, an_out}, 32'h80);
    chk("rst_seg", {24'd0, seg_out}, 32'h3F);
    chk("rst_pos", {28'd0, pos_out}, 32'h0);
    rst = 1'b0;

    // Idle scan and first scroll step
    tick(5);
    chk("t1_an_slot1", {24'd0, an_out}, 32'h40);
    chk("t1_seg_slot1", {24'd0, seg_out}, 32'h06);
    tick(58);
    chk("t1_pos_before", {28'd0, pos_out}, 32'h0);
    tick(1);
    chk("t1_pos_after", {28'd0, pos_out}, 32'h1);
    wait_an(8'h80);
    chk("t1_left_digit", {24'd0, seg_out}, 32'h06);

    // Wrap 15 -> 0
    wait_pos(4'd15, 1200);
    wait_an(8'h40);
    chk("t2_wrap_glyph", {24'd0, seg_out}, 32'h3F);
    wait_pos(4'd0, 100);

    // Pause and resume from frozen count
    wait_pos(4'd3, 300);
    tick(30);
    pause_in = 1'b1;
    tick(500);
    chk("t3_frozen_pos", {28'd0, pos_out}, 32'h3);
    pause_in = 1'b0;
    n = 0;
    while (pos_out !== 4'd4 && n < 200) begin tick(1); n++; end
    chk("t3_resume_cycles", n, 34);

    // Held restart produces one event
    wait_pos(4'd7, 200);
    restart_in = 1'b1;
    tick(2);
    chk("t4_pos_pre_evt", {28'd0, pos_out}, 32'h7);
    tick(1);
    chk("t4_pos_evt", {28'd0, pos_out}, 32'h0);
    tick(63);
    chk("t4_pos_hold", {28'd0, pos_out}, 32'h0);
    tick(1);
    chk("t4_pos_step", {28'd0, pos_out}, 32'h1);
    tick(133);
    chk("t4_single_evt", {28'd0, pos_out}, 32'h3);
    restart_in = 1'b0;

    // Restart coincident with scroll wrap
    tick(5);
    cur = int'(pos_out);
    n = 0;
    while (int'(pos_out) == cur && n < 100) begin tick(1); n++; end
    chk("t5_step_seen", {31'd0, (int'(pos_out) != cur)}, 32'h1);
    tick(61);
    restart_in = 1'b1;
    tick(3);
    chk("t5_coincident", {28'd0, pos_out}, 32'h0);

    // Mid-scroll reset with restart still high afterwards
    tick(20);
    rst = 1'b1;
    tick(1);
    chk("t5_rst_an", {24'd0, an_out}, 32'h80);
    chk("t5_rst_seg", {24'd0, seg_out}, 32'h3F);
    chk("t5_rst_pos", {28'd0, pos_out}, 32'h0);
    tick(2);
    rst = 1'b0;
    tick(66);
    chk("t5_post_rst_hold", {28'd0, pos_out}, 32'h0);
    tick(1);
    chk("t5_post_rst_step", {28'd0, pos_out}, 32'h1);
    restart_in = 1'b0;

`ifdef PAUSE_BLINK_EN
    tick(5);
    pause_in = 1'b1;
    tick(2);
    n = 0;
    for (int i = 0; i < 64; i++) begin
      tick(1);
      if (seg_out == 8'h00) n++;
    end
    chk("t6_blank_cycles", n, 32);
    n = 0;
    while (seg_out !== 8'h00 && n < 40) begin tick(1); n++; end
    chk("t6_in_blank", {24'd0, seg_out}, 32'h0);
    pause_in = 1'b0;
    tick(3);
    chk("t6_unblank", {31'd0, (seg_out != 8'h00)}, 32'h1);
`endif

    tick(10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
